// File: rtl/endian_swap_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : endian_swap_scheduler_if
// Description : Requester, consumer and status signals of the endian swap
//               scheduler. The slave modport is the scheduler's view. The
//               master modport is the view of the requesters and consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface endian_swap_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [1:0]        req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [1:0]        req1_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src, busy
  );

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src, busy
  );
endinterface
`default_nettype wire

// File: rtl/endian_swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : endian_swap_scheduler
// Description : Round-robin sharing of one 32-bit bit/byte-order swap
//               datapath between two requesters. The result is held in a
//               single output register with a valid/ready handshake and is
//               tagged with its source.
//               The optional macro SWAP_STATS_EN adds saturating statistics
//               counters: accepts per requester and output stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module endian_swap_scheduler #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire                          clk,
  input  wire                          rst,
  endian_swap_scheduler_if.slave       bus
`ifdef SWAP_STATS_EN
  ,
  output logic [CNT_W-1:0]             stat_cnt0,
  output logic [CNT_W-1:0]             stat_cnt1,
  output logic [CNT_W-1:0]             stat_stall
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_src;

  logic              w_slot_free;
  logic              w_grant;
  logic              w_accept0;
  logic              w_accept1;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;
  logic [1:0]        w_sel_mode;
  logic [DATA_W-1:0] w_swapped;

  // Transform of one word: 00 pass, 01 bit reverse, 10 byte swap, 11 halfword swap.
  function automatic logic [DATA_W-1:0] f_swap(input logic [DATA_W-1:0] d,
                                               input logic [1:0]        m);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'b00: r = d;
      2'b01: for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      2'b10: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
      2'b11: r = {d[15:0], d[31:16]};
      default: r = d;
    endcase
    return r;
  endfunction

  // A slot is free if the register is empty or is being drained this cycle.
  assign w_slot_free = (r_state == ST_EMPTY) | (r_out_valid & bus.out_ready);

  // Round-robin pick: a lone requester wins, a contest goes to the one not last served.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      w_grant = 1'b1;
    end else if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end
  end

  assign w_accept0 = w_slot_free & bus.req0_valid & (w_grant == 1'b0);
  assign w_accept1 = w_slot_free & bus.req1_valid & (w_grant == 1'b1);
  assign w_accept  = w_accept0 | w_accept1;

  assign w_sel_data = w_grant ? bus.req1_data : bus.req0_data;
  assign w_sel_mode = w_grant ? bus.req1_mode : bus.req0_mode;
  assign w_swapped  = f_swap(w_sel_data, w_sel_mode);

  // EMPTY/FULL controller with the output register, source tag and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_data  <= w_swapped;
            r_out_src   <= w_grant;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            // Drain and reload in the same cycle, no bubble.
            r_out_valid <= 1'b1;
            r_out_data  <= w_swapped;
            r_out_src   <= w_grant;
          end else if (bus.out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_accept0;
  assign bus.req1_ready = w_accept1;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
  assign bus.busy       = (r_state == ST_FULL) | bus.req0_valid | bus.req1_valid;

`ifdef SWAP_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_stall;
  logic             w_stall;

  assign w_stall = r_out_valid & ~bus.out_ready;

  // Saturating counters of accepts per requester and of output stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_accept0 && (r_cnt0 != '1)) r_cnt0  <= r_cnt0 + c_CNT_ONE;
      if (w_accept1 && (r_cnt1 != '1)) r_cnt1  <= r_cnt1 + c_CNT_ONE;
      if (w_stall && (r_stall != '1))  r_stall <= r_stall + c_CNT_ONE;
    end
  end

  assign stat_cnt0  = r_cnt0;
  assign stat_cnt1  = r_cnt1;
  assign stat_stall = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_endian_swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_endian_swap_scheduler
// Description : Directed self-checking bench for endian_swap_scheduler.
//               When SWAP_STATS_EN is defined, it also checks the statistics
//               counters, using a 4-bit counter width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_endian_swap_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  endian_swap_scheduler_if #(.DATA_W(32)) bus ();

`ifdef SWAP_STATS_EN
  logic [3:0] stat_cnt0;
  logic [3:0] stat_cnt1;
  logic [3:0] stat_stall;

  endian_swap_scheduler #(.DATA_W(32), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_stall (stat_stall)
  );
`else
  endian_swap_scheduler #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before anything is sampled or driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word from requester src, check the accept, then check the result and the drain.
  task automatic send(input logic src, input logic [31:0] d, input logic [1:0] m,
                      input logic [31:0] exp, input string tag);
    if (src) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_mode = m;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_mode = m;
    end
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, {31'd0, src ? bus.req1_ready : bus.req0_ready}, 32'd1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, "_data"},  bus.out_data, exp);
    chk({tag, "_src"},   {31'd0, bus.out_src}, {31'd0, src});
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    step();
    chk({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_mode = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_mode = 2'b00;
    bus.out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",  bus.out_data, 32'd0);
    chk("rst_src",   {31'd0, bus.out_src}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);

    // Each mode, with both requesters taking turns.
    send(1'b0, 32'h12345678, 2'b10, 32'h78563412, "bswap");
    send(1'b1, 32'h00000001, 2'b01, 32'h80000000, "brev");
    send(1'b0, 32'hAABBCCDD, 2'b11, 32'hCCDDAABB, "hswap");
    send(1'b1, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, "pass");

    // Both requesters always valid: grants alternate 0,1,0,1... with no idle cycle.
    bus.req0_valid = 1'b1; bus.req0_data = 32'h11111111; bus.req0_mode = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_data = 32'h000000F0; bus.req1_mode = 2'b10;
    bus.out_ready  = 1'b1;
    #1;
    chk("busy_req", {31'd0, bus.busy}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("alt_r0", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_r1", {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk("alt_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("alt_src",   {31'd0, bus.out_src}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_data",  bus.out_data, (k % 2 == 1) ? 32'hF0000000 : 32'h11111111);
    end

    // Backpressure: the held word stays put and nobody is accepted.
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_r0",   {31'd0, bus.req0_ready}, 32'd0);
      chk("stall_r1",   {31'd0, bus.req1_ready}, 32'd0);
      chk("stall_data", bus.out_data, 32'hF0000000);
      chk("stall_src",  {31'd0, bus.out_src}, 32'd1);
      chk("stall_vld",  {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    // Release: drain and reload from requester 0 in the same edge.
    bus.out_ready = 1'b1;
    #1;
    chk("rel_r0", {31'd0, bus.req0_ready}, 32'd1);
    step();
    chk("rel_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rel_src",   {31'd0, bus.out_src}, 32'd0);
    chk("rel_data",  bus.out_data, 32'h11111111);

    // Reset while FULL: the word is discarded and the grant history returns to favour requester 0.
    bus.req0_valid = 1'b0;
    bus.out_ready  = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_data",  bus.out_data, 32'd0);
    bus.req0_valid = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    chk("mrst_r0", {31'd0, bus.req0_ready}, 32'd1);
    chk("mrst_r1", {31'd0, bus.req1_ready}, 32'd0);
    step();
    chk("mrst_src",  {31'd0, bus.out_src}, 32'd0);
    chk("mrst_out",  bus.out_data, 32'h11111111);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_busy",  {31'd0, bus.busy}, 32'd0);

`ifdef SWAP_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_rst0",  {28'd0, stat_cnt0}, 32'd0);
    chk("st_rstst", {28'd0, stat_stall}, 32'd0);
    bus.req0_valid = 1'b1;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("st_sat0", {28'd0, stat_cnt0}, 32'd15);
    chk("st_cnt1", {28'd0, stat_cnt1}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.out_ready  = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("st_stall", {28'd0, stat_stall}, 32'd3);
    bus.out_ready = 1'b1;
    step();
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
